// File: rtl/ysyx_25040111_axi_arbiter.sv
// Two-requester AXI4 master-port arbiter: IFU (read-only) and LSU (read/write)
// share io_master, one single-beat transaction at a time, zero-latency passthrough.
module ysyx_25040111_axi_arbiter #(
  parameter bit         LSU_PRIO = 1'b1,
  parameter logic [3:0] IFU_ID   = 4'h0,
  parameter logic [3:0] LSU_ID   = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  // IFU read
  input  logic        ifu_arvalid,
  input  logic [31:0] ifu_araddr,
  input  logic [2:0]  ifu_arsize,
  output logic        ifu_arready,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  input  logic        ifu_rready,
  // LSU read
  input  logic        lsu_arvalid,
  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  output logic        lsu_arready,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rlast,
  input  logic        lsu_rready,
  // LSU write
  input  logic        lsu_awvalid,
  input  logic [31:0] lsu_awaddr,
  input  logic [2:0]  lsu_awsize,
  output logic        lsu_awready,
  input  logic        lsu_wvalid,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wlast,
  output logic        lsu_wready,
  output logic        lsu_bvalid,
  output logic [1:0]  lsu_bresp,
  input  logic        lsu_bready,
  // io_master
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, IRD_A, IRD_D, LRD_A, LRD_D, LWR_A, LWR_W, LWR_B
  } state_t;

  state_t state_q, state_d;
  logic   rr_last_q, rr_last_d;  // 0 = IFU served last, 1 = LSU served last
  logic   err_q, err_d;
  logic   lsu_req, lsu_win;
  logic   unused_wlast;

  // Single-beat writes: the LSU's own wlast carries no information.
  assign unused_wlast = lsu_wlast;
  assign err          = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  assign lsu_req = lsu_awvalid | lsu_arvalid;
  assign lsu_win = lsu_req & (~ifu_arvalid | LSU_PRIO | ~rr_last_q);

  always_comb begin
    state_d           = state_q;
    rr_last_d         = rr_last_q;
    err_d             = err_q;
    ifu_arready       = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rdata         = 32'd0;
    ifu_rresp         = 2'd0;
    ifu_rlast         = 1'b0;
    lsu_arready       = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_rdata         = 32'd0;
    lsu_rresp         = 2'd0;
    lsu_rlast         = 1'b0;
    lsu_awready       = 1'b0;
    lsu_wready        = 1'b0;
    lsu_bvalid        = 1'b0;
    lsu_bresp         = 2'd0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = 32'd0;
    io_master_awid    = 4'd0;
    io_master_awlen   = 8'd0;
    io_master_awsize  = 3'd0;
    io_master_awburst = 2'd0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = 32'd0;
    io_master_wstrb   = 4'd0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = 32'd0;
    io_master_arid    = 4'd0;
    io_master_arlen   = 8'd0;
    io_master_arsize  = 3'd0;
    io_master_arburst = 2'd0;
    io_master_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_win) state_d = lsu_awvalid ? LWR_A : LRD_A;
        else if (ifu_arvalid) state_d = IRD_A;
      end
      IRD_A: begin
        io_master_arvalid = 1'b1;
        io_master_araddr  = ifu_araddr;
        io_master_arsize  = ifu_arsize;
        io_master_arid    = IFU_ID;
        io_master_arburst = 2'b01;
        ifu_arready       = io_master_arready;
        if (io_master_arready) state_d = IRD_D;
      end
      IRD_D: begin
        io_master_rready = ifu_rready;
        ifu_rvalid       = io_master_rvalid;
        ifu_rdata        = io_master_rdata;
        ifu_rresp        = io_master_rresp;
        ifu_rlast        = io_master_rlast;
        if (io_master_rvalid && ifu_rready) begin
          state_d   = IDLE;
          rr_last_d = 1'b0;
          if (io_master_rresp != 2'd0 || io_master_rid != IFU_ID || !io_master_rlast)
            err_d = 1'b1;
        end
      end
      LRD_A: begin
        io_master_arvalid = 1'b1;
        io_master_araddr  = lsu_araddr;
        io_master_arsize  = lsu_arsize;
        io_master_arid    = LSU_ID;
        io_master_arburst = 2'b01;
        lsu_arready       = io_master_arready;
        if (io_master_arready) state_d = LRD_D;
      end
      LRD_D: begin
        io_master_rready = lsu_rready;
        lsu_rvalid       = io_master_rvalid;
        lsu_rdata        = io_master_rdata;
        lsu_rresp        = io_master_rresp;
        lsu_rlast        = io_master_rlast;
        if (io_master_rvalid && lsu_rready) begin
          state_d   = IDLE;
          rr_last_d = 1'b1;
          if (io_master_rresp != 2'd0 || io_master_rid != LSU_ID || !io_master_rlast)
            err_d = 1'b1;
        end
      end
      LWR_A: begin
        io_master_awvalid = 1'b1;
        io_master_awaddr  = lsu_awaddr;
        io_master_awsize  = lsu_awsize;
        io_master_awid    = LSU_ID;
        io_master_awburst = 2'b01;
        lsu_awready       = io_master_awready;
        if (io_master_awready) state_d = LWR_W;
      end
      LWR_W: begin
        io_master_wvalid = lsu_wvalid;
        io_master_wdata  = lsu_wdata;
        io_master_wstrb  = lsu_wstrb;
        io_master_wlast  = 1'b1;
        lsu_wready       = io_master_wready;
        if (lsu_wvalid && io_master_wready) state_d = LWR_B;
      end
      LWR_B: begin
        io_master_bready = lsu_bready;
        lsu_bvalid       = io_master_bvalid;
        lsu_bresp        = io_master_bresp;
        if (io_master_bvalid && lsu_bready) begin
          state_d   = IDLE;
          rr_last_d = 1'b1;
          if (io_master_bresp != 2'd0 || io_master_bid != LSU_ID) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
